// File: rtl/adc_capture_ctrl_if.sv
// rtl/adc_capture_ctrl_if.sv - sample-pair input and host FIFO write port bundle
interface adc_capture_ctrl_if;
  logic [7:0]  ch0_byte;
  logic [7:0]  ch1_byte;
  logic        sample_valid;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [31:0] fifo_din;

  modport master (
    output ch0_byte, ch1_byte, sample_valid, fifo_full,
    input  fifo_wr_en, fifo_din
  );

  modport slave (
    input  ch0_byte, ch1_byte, sample_valid, fifo_full,
    output fifo_wr_en, fifo_din
  );
endinterface

// File: rtl/adc_capture_ctrl.sv
// rtl/adc_capture_ctrl.sv - two-channel ADC sample packer with trigger arm and host FIFO writer
module adc_capture_ctrl #(
  parameter int LEN_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  adc_capture_ctrl_if.slave bus,
  input  logic              capture_start_i,
  input  logic              trig_en_i,
  input  logic              trigger_i,
  input  logic              abort_i,
  input  logic [LEN_W-1:0]  capture_len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o
);

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] cnt_inc;
  logic             half_q, half_d;
  logic [15:0]      lo_q, lo_d;
  logic             wr_q, wr_d;
  logic [31:0]      din_q, din_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      pair;

  assign pair    = {bus.ch1_byte, bus.ch0_byte};
  assign cnt_inc = cnt_q + LEN_W'(1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    lo_d    = lo_q;
    wr_d    = 1'b0;
    din_d   = din_q;
    done_d  = (state_q == DONE);
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (capture_start_i) begin
          len_d  = capture_len_i;
          cnt_d  = '0;
          half_d = 1'b0;
          ovf_d  = 1'b0;
          if (capture_len_i == '0) begin
            state_d = DONE;
          end else if (trig_en_i) begin
            state_d = ARM;
          end else begin
            state_d = CAPTURE;
          end
        end
      end
      ARM: begin
        // The pair present in the trigger cycle is discarded; capture begins next cycle.
        if (abort_i) begin
          state_d = IDLE;
        end else if (trigger_i) begin
          state_d = CAPTURE;
          half_d  = 1'b0;
        end
      end
      CAPTURE: begin
        if (abort_i) begin
          state_d = IDLE;
          half_d  = 1'b0;
        end else if (bus.sample_valid) begin
          if (!half_q) begin
            lo_d   = pair;
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            cnt_d  = cnt_inc;
            // A word that meets a full FIFO is dropped but still counts toward the length.
            if (bus.fifo_full) begin
              ovf_d = 1'b1;
            end else begin
              wr_d  = 1'b1;
              din_d = {pair, lo_q};
            end
            if (cnt_inc == len_q) begin
              state_d = DONE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      half_q  <= 1'b0;
      lo_q    <= '0;
      wr_q    <= 1'b0;
      din_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      lo_q    <= lo_d;
      wr_q    <= wr_d;
      din_q   <= din_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.fifo_wr_en = wr_q;
  assign bus.fifo_din   = din_q;
  assign busy_o         = (state_q == ARM) || (state_q == CAPTURE);
  assign done_o         = done_q;
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb/tb_adc_capture_ctrl.sv - self-checking bench for adc_capture_ctrl with a word-list reference model
module tb_adc_capture_ctrl;
  localparam int LEN_W = 16;
  localparam int N     = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             capture_start, trig_en, trigger, abort;
  logic [LEN_W-1:0] capture_len;
  logic             busy, done, overflow;

  int n_checks = 0;
  int n_fail   = 0;

  adc_capture_ctrl_if bus ();

  adc_capture_ctrl #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .capture_start_i(capture_start), .trig_en_i(trig_en), .trigger_i(trigger),
    .abort_i(abort), .capture_len_i(capture_len),
    .busy_o(busy), .done_o(done), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  bit               s_rst[N], s_start[N], s_te[N], s_trig[N], s_abort[N], s_valid[N], s_full[N];
  logic [7:0]       s_ch0[N], s_ch1[N];
  logic [LEN_W-1:0] s_len[N];
  logic             o_wr[N], o_busy[N], o_done[N], o_ovf[N];
  logic [31:0]      o_din[N];
  bit               e_wr[N], e_busy[N], e_done[N];
  logic [31:0]      e_din[N];
  bit               e_ovf;

  task automatic apply_idle;
    rst = 1'b0; capture_start = 1'b0; capture_len = '0; trig_en = 1'b0; trigger = 1'b0; abort = 1'b0;
    bus.sample_valid = 1'b0; bus.ch0_byte = '0; bus.ch1_byte = '0; bus.fifo_full = 1'b0;
  endtask

  task automatic do_reset;
    apply_idle;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic clear_stim;
    for (int c = 0; c < N; c++) begin
      s_rst[c] = 0; s_start[c] = 0; s_te[c] = 0; s_trig[c] = 0; s_abort[c] = 0;
      s_valid[c] = 0; s_full[c] = 0; s_len[c] = '0;
      s_ch0[c] = 8'($urandom); s_ch1[c] = 8'($urandom);
    end
  endtask

  task automatic run_stim;
    for (int i = 0; i < N; i++) begin
      rst = s_rst[i]; capture_start = s_start[i]; capture_len = s_len[i]; trig_en = s_te[i];
      trigger = s_trig[i]; abort = s_abort[i];
      bus.sample_valid = s_valid[i]; bus.ch0_byte = s_ch0[i]; bus.ch1_byte = s_ch1[i]; bus.fifo_full = s_full[i];
      @(negedge clk);
      o_wr[i] = bus.fifo_wr_en; o_din[i] = bus.fifo_din; o_busy[i] = busy; o_done[i] = done; o_ovf[i] = overflow;
      @(posedge clk); #1;
    end
    apply_idle;
  endtask

  function automatic int num_writes();
    int n = 0;
    for (int j = 0; j < N; j++) if (o_wr[j] === 1'b1) n++;
    return n;
  endfunction

  function automatic int num_dones();
    int n = 0;
    for (int j = 0; j < N; j++) if (o_done[j] === 1'b1) n++;
    return n;
  endfunction

  function automatic int first_write();
    for (int j = 0; j < N; j++) if (o_wr[j] === 1'b1) return j;
    return -1;
  endfunction

  function automatic int first_done();
    for (int j = 0; j < N; j++) if (o_done[j] === 1'b1) return j;
    return -1;
  endfunction

  // Capture started at cycle 0 with length L; pairs are grouped into words from the
  // first capture cycle, each finished word shows up one cycle after its second pair.
  task automatic model(input int L, input bit T, input int ab, output int last);
    int cap_from, c_last, k;
    bit have_lo;
    logic [15:0] lo;
    logic [31:0] cur;
    for (int j = 0; j < N; j++) begin e_wr[j] = 0; e_busy[j] = 0; e_done[j] = 0; e_din[j] = '0; end
    e_ovf = 0; c_last = -1; cap_from = -1; k = 0; have_lo = 0; lo = '0;
    if (L == 0) begin
      e_done[2] = 1;
      last = 0;
    end else begin
      if (!T) cap_from = 1;
      else begin
        for (int t = 1; t < N; t++) begin
          if (ab >= 0 && t >= ab) break;
          if (s_trig[t]) begin cap_from = t + 1; break; end
        end
      end
      if (cap_from > 0) begin
        for (int c = cap_from; c < N; c++) begin
          if (ab >= 0 && c >= ab) break;
          if (s_valid[c]) begin
            if (!have_lo) begin
              lo = {s_ch1[c], s_ch0[c]};
              have_lo = 1;
            end else begin
              have_lo = 0;
              k++;
              if (s_full[c]) e_ovf = 1;
              else if (c + 1 < N) begin e_wr[c+1] = 1; e_din[c+1] = {s_ch1[c], s_ch0[c], lo}; end
              if (k == L) begin c_last = c; break; end
            end
          end
        end
      end
      if (c_last >= 0) last = c_last;
      else if (ab >= 0) last = ab;
      else last = N - 1;
      for (int j = 1; j <= last; j++) e_busy[j] = 1;
      if (c_last >= 0 && c_last + 2 < N) e_done[c_last+2] = 1;
    end
    cur = '0;
    for (int j = 0; j < N; j++) begin
      if (e_wr[j]) cur = e_din[j];
      else e_din[j] = cur;
    end
  endtask

  task automatic test_reset;
    apply_idle;
    rst = 1'b1; capture_start = 1'b1; capture_len = 16'd5; bus.sample_valid = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b expected 0", bus.fifo_wr_en); end
    n_checks++; if (bus.fifo_din !== 32'h0) begin n_fail++; $display("FAIL reset_din: got %h expected 00000000", bus.fifo_din); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    @(posedge clk); #1;
    apply_idle;
  endtask

  task automatic test_basic;
    do_reset; clear_stim;
    for (int c = 1; c < N - 4; c++) begin s_valid[c] = 1; s_ch0[c] = 8'(2*c - 1); s_ch1[c] = 8'(2*c); end
    s_start[0] = 1; s_len[0] = 16'd3;
    run_stim;
    n_checks++; if (num_writes() != 3) begin n_fail++; $display("FAIL basic_nwr: got %0d expected 3", num_writes()); end
    n_checks++; if (o_wr[3] !== 1'b1 || o_din[3] !== 32'h04030201) begin n_fail++; $display("FAIL basic_w0: got wr=%b din=%h expected 1 04030201", o_wr[3], o_din[3]); end
    n_checks++; if (o_din[4] !== 32'h04030201) begin n_fail++; $display("FAIL basic_hold: got %h expected 04030201", o_din[4]); end
    n_checks++; if (o_wr[5] !== 1'b1 || o_din[5] !== 32'h08070605) begin n_fail++; $display("FAIL basic_w1: got wr=%b din=%h expected 1 08070605", o_wr[5], o_din[5]); end
    n_checks++; if (o_wr[7] !== 1'b1 || o_din[7] !== 32'h0C0B0A09) begin n_fail++; $display("FAIL basic_w2: got wr=%b din=%h expected 1 0c0b0a09", o_wr[7], o_din[7]); end
    n_checks++; if (first_done() != 8 || num_dones() != 1) begin n_fail++; $display("FAIL basic_done: got first=%0d count=%0d expected 8 1", first_done(), num_dones()); end
    n_checks++; if (o_busy[1] !== 1'b1 || o_busy[8] !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b/%b expected 1/0", o_busy[1], o_busy[8]); end
  endtask

  task automatic test_trigger;
    do_reset; clear_stim;
    for (int c = 1; c < N - 4; c++) begin s_valid[c] = 1; s_ch0[c] = 8'(c); s_ch1[c] = 8'(c) | 8'h80; end
    s_start[0] = 1; s_len[0] = 16'd2; s_te[0] = 1; s_trig[10] = 1;
    run_stim;
    n_checks++; if (first_write() != 13) begin n_fail++; $display("FAIL trig_first: got %0d expected 13", first_write()); end
    n_checks++; if (o_din[13] !== 32'h8C0C8B0B) begin n_fail++; $display("FAIL trig_w0: got %h expected 8c0c8b0b", o_din[13]); end
    n_checks++; if (o_wr[15] !== 1'b1 || o_din[15] !== 32'h8E0E8D0D) begin n_fail++; $display("FAIL trig_w1: got wr=%b din=%h expected 1 8e0e8d0d", o_wr[15], o_din[15]); end
    n_checks++; if (num_writes() != 2 || first_done() != 16) begin n_fail++; $display("FAIL trig_end: got nwr=%0d done=%0d expected 2 16", num_writes(), first_done()); end
    n_checks++; if (o_busy[10] !== 1'b1) begin n_fail++; $display("FAIL trig_arm_busy: got %b expected 1", o_busy[10]); end
  endtask

  task automatic test_overflow;
    do_reset; clear_stim;
    for (int c = 1; c < N - 4; c++) s_valid[c] = 1;
    s_start[0] = 1; s_len[0] = 16'd4; s_full[4] = 1;
    run_stim;
    n_checks++; if (num_writes() != 3 || o_wr[5] !== 1'b0) begin n_fail++; $display("FAIL ovf_nwr: got %0d wr5=%b expected 3 0", num_writes(), o_wr[5]); end
    n_checks++; if (o_ovf[N-1] !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", o_ovf[N-1]); end
    n_checks++; if (first_done() != 10 || num_dones() != 1) begin n_fail++; $display("FAIL ovf_done: got %0d/%0d expected 10/1", first_done(), num_dones()); end
    clear_stim;
    for (int c = 1; c < N - 4; c++) s_valid[c] = 1;
    s_start[0] = 1; s_len[0] = 16'd1;
    run_stim;
    n_checks++; if (o_ovf[0] !== 1'b1 || o_ovf[1] !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b->%b expected 1->0", o_ovf[0], o_ovf[1]); end
  endtask

  task automatic test_abort;
    do_reset; clear_stim;
    for (int c = 1; c < N - 4; c++) s_valid[c] = 1;
    s_start[0] = 1; s_len[0] = 16'd3; s_abort[4] = 1;
    run_stim;
    n_checks++; if (num_writes() != 1 || o_wr[3] !== 1'b1) begin n_fail++; $display("FAIL abort_nwr: got %0d wr3=%b expected 1 1", num_writes(), o_wr[3]); end
    n_checks++; if (o_busy[4] !== 1'b1 || o_busy[5] !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b/%b expected 1/0", o_busy[4], o_busy[5]); end
    n_checks++; if (num_dones() != 0) begin n_fail++; $display("FAIL abort_done: got %0d expected 0", num_dones()); end
  endtask

  task automatic test_zero_len;
    do_reset; clear_stim;
    for (int c = 1; c < N - 4; c++) s_valid[c] = 1;
    s_start[0] = 1; s_len[0] = '0; s_start[1] = 1; s_len[1] = 16'd5;
    run_stim;
    n_checks++; if (num_writes() != 0) begin n_fail++; $display("FAIL zero_nwr: got %0d expected 0", num_writes()); end
    n_checks++; if (first_done() != 2 || num_dones() != 1) begin n_fail++; $display("FAIL zero_done: got %0d/%0d expected 2/1", first_done(), num_dones()); end
    n_checks++; if (o_busy[1] !== 1'b0) begin n_fail++; $display("FAIL zero_busy: got %b expected 0", o_busy[1]); end
    do_reset; clear_stim;
    s_start[0] = 1; s_len[0] = 16'd2; s_te[0] = 1; s_start[5] = 1; s_len[5] = '0;
    run_stim;
    n_checks++; if (num_dones() != 0 || o_busy[N-1] !== 1'b1) begin n_fail++; $display("FAIL busy_start_ignored: got done=%0d busy=%b expected 0 1", num_dones(), o_busy[N-1]); end
  endtask

  task automatic test_rst_mid;
    do_reset; clear_stim;
    for (int c = 1; c < N - 4; c++) s_valid[c] = 1;
    s_start[0] = 1; s_len[0] = 16'd4; s_full[2] = 1; s_rst[5] = 1;
    run_stim;
    n_checks++; if (o_ovf[5] !== 1'b1 || o_wr[5] !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got ovf=%b wr=%b expected 1 1", o_ovf[5], o_wr[5]); end
    n_checks++; if (o_wr[6] !== 1'b0 || o_din[6] !== 32'h0 || o_busy[6] !== 1'b0 || o_ovf[6] !== 1'b0 || o_done[6] !== 1'b0) begin
      n_fail++; $display("FAIL rst_outputs: got wr=%b din=%h busy=%b ovf=%b done=%b expected all 0", o_wr[6], o_din[6], o_busy[6], o_ovf[6], o_done[6]);
    end
    n_checks++; if (num_writes() != 1 || num_dones() != 0) begin n_fail++; $display("FAIL rst_after: got nwr=%0d ndone=%0d expected 1 0", num_writes(), num_dones()); end
  endtask

  task automatic test_random(input int iters);
    int L, ab, last, s;
    bit T;
    for (int it = 0; it < iters; it++) begin
      do_reset; clear_stim;
      L = $urandom_range(8, 0);
      T = ($urandom_range(1, 0) == 1);
      for (int c = 0; c < N; c++) begin
        s_valid[c] = (c < N - 4) && ($urandom_range(9, 0) < 7);
        s_full[c]  = ($urandom_range(9, 0) < 2);
        s_trig[c]  = ($urandom_range(19, 0) == 0);
        s_len[c]   = LEN_W'($urandom);
        s_te[c]    = ($urandom_range(1, 0) == 1);
      end
      s_start[0] = 1; s_len[0] = LEN_W'(L); s_te[0] = T;
      ab = ($urandom_range(2, 0) == 0) ? int'($urandom_range(N - 6, 1)) : -1;
      if (ab >= 0) s_abort[ab] = 1;
      model(L, T, ab, last);
      s = (last >= 1) ? int'($urandom_range(last, 1)) : 1;
      s_start[s] = 1;
      run_stim;
      for (int j = 0; j < N; j++) begin
        n_checks++; if (o_wr[j] !== e_wr[j]) begin n_fail++; $display("FAIL rnd_wr it%0d cyc%0d: got %b expected %b", it, j, o_wr[j], e_wr[j]); end
        n_checks++; if (o_din[j] !== e_din[j]) begin n_fail++; $display("FAIL rnd_din it%0d cyc%0d: got %h expected %h", it, j, o_din[j], e_din[j]); end
        n_checks++; if (o_busy[j] !== e_busy[j]) begin n_fail++; $display("FAIL rnd_busy it%0d cyc%0d: got %b expected %b", it, j, o_busy[j], e_busy[j]); end
        n_checks++; if (o_done[j] !== e_done[j]) begin n_fail++; $display("FAIL rnd_done it%0d cyc%0d: got %b expected %b", it, j, o_done[j], e_done[j]); end
      end
      n_checks++; if (o_ovf[N-1] !== e_ovf) begin n_fail++; $display("FAIL rnd_ovf it%0d: got %b expected %b", it, o_ovf[N-1], e_ovf); end
    end
  endtask

  initial begin
    apply_idle;
    test_reset;
    test_basic;
    test_trigger;
    test_overflow;
    test_abort;
    test_zero_len;
    test_rst_mid;
    test_random(30);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
